// File: rtl/johnson_seq_ctrl.sv
// ---------------------------------------------------------------------------
// johnson_seq_ctrl
//
// Run controller for a WIDTH-bit Johnson counter.  A run is requested with
// start, executes a programmed number of full rotations (2*WIDTH states
// each), and ends with a one-cycle done pulse.  The count is decoded into
// one-hot phase enables and a phase index, so downstream datapath blocks can
// use it as a multi-phase enable scheduler.  Illegal counter values are
// squashed back to all-zero on the next edge.
//
// Handshake: start is accepted only in IDLE.  An accepted start latches
// cycles and raises busy on the following cycle.  busy stays high through
// RUN and PAUSE.  done pulses for exactly one cycle when the run ends, with
// aborted high alongside it if abort ended the run.  start is ignored
// whenever busy or done is high.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   start      in   run request (sampled only in IDLE)
//   cycles     in   number of rotations, latched on accepted start
//   pause      in   hold the counter (RUN/PAUSE only)
//   abort      in   end the run (RUN/PAUSE only), wins over pause
//   count      out  Johnson counter value
//   phase      out  one-hot decode of count, zero outside RUN/PAUSE
//   phase_idx  out  position of count in the Johnson sequence
//   busy       out  high in RUN or PAUSE
//   wrap       out  one-cycle pulse after each completed rotation
//   done       out  one-cycle pulse in DONE
//   aborted    out  high with done when the run was aborted
// ---------------------------------------------------------------------------
module johnson_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int CYC_W  = 8,
    parameter int PIDX_W = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CYC_W-1:0]     cycles,
    input  logic                 pause,
    input  logic                 abort,
    output logic [WIDTH-1:0]     count,
    output logic [2*WIDTH-1:0]   phase,
    output logic [PIDX_W-1:0]    phase_idx,
    output logic                 busy,
    output logic                 wrap,
    output logic                 done,
    output logic                 aborted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Final state of a rotation: only the MSB set (1000 for WIDTH=4).
    localparam logic [WIDTH-1:0] LAST_CNT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [CYC_W-1:0]   rem_q, rem_d;
    logic               wrap_q, wrap_d;
    logic               aborted_q, aborted_d;

    logic               cnt_legal;
    logic [PIDX_W-1:0]  cnt_idx;
    logic [2*WIDTH-1:0] cnt_onehot;

    // Johnson pattern at sequence position i: the first WIDTH+1 positions
    // fill ones from the LSB, the remaining ones drain zeros in from the LSB.
    function automatic logic [WIDTH-1:0] johnson_pat(input int i);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (i <= WIDTH) p[b] = (b < i);
            else            p[b] = (b >= i - WIDTH);
        end
        return p;
    endfunction

    // Decode of the current count: legality, sequence position and one-hot.
    always_comb begin
        cnt_legal  = 1'b0;
        cnt_idx    = '0;
        cnt_onehot = '0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (count_q == johnson_pat(i)) begin
                cnt_legal     = 1'b1;
                cnt_idx       = PIDX_W'(i);
                cnt_onehot[i] = 1'b1;
            end
        end
    end

    // State register and datapath flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            wrap_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            wrap_q    <= wrap_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        wrap_d    = 1'b0;
        aborted_d = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cycles != '0) begin
                        state_d = S_RUN;
                        rem_d   = cycles;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d   = S_DONE;
                    count_d   = '0;
                    aborted_d = 1'b1;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
                    if (count_q == LAST_CNT) begin
                        wrap_d = 1'b1;
                        if (rem_q != '0) rem_d = rem_q - CYC_W'(1);
                        // remaining never reads zero in RUN; <= 1 just
                        // keeps a corrupted zero from running forever.
                        if (rem_q <= CYC_W'(1)) state_d = S_DONE;
                    end
                end
            end

            S_PAUSE: begin
                if (abort) begin
                    state_d   = S_DONE;
                    count_d   = '0;
                    aborted_d = 1'b1;
                end else if (!pause) begin
                    // Count holds on this edge too, hence the extra cycle.
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                state_d   = S_IDLE;
                aborted_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Self-correction: any illegal value returns to zero in every state.
        // A rotation interrupted this way is neither counted nor wrapped,
        // because LAST_CNT is legal and so cannot trigger the wrap above.
        if (!cnt_legal) count_d = '0;
    end

    // Outputs, all decoded from registers.
    always_comb begin
        busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
        done      = (state_q == S_DONE);
        aborted   = aborted_q;
        wrap      = wrap_q;
        count     = count_q;
        phase_idx = cnt_idx;
        phase     = busy ? cnt_onehot : '0;
    end

endmodule
